// File: rtl/lianliankan_pkg.sv
// Shared board geometry and selection-state encoding for the lianliankan
// board controller.
package lianliankan_pkg;

  localparam int unsigned BOARD_COLS = 8;
  localparam int unsigned BOARD_ROWS = 8;
  localparam int unsigned BOARD_XW   = 3;
  localparam int unsigned BOARD_YW   = 3;

  typedef enum logic [1:0] {
    SEL_IDLE = 2'd0,
    SEL_ONE  = 2'd1,
    SEL_PEND = 2'd2
  } sel_state_e;

  // Repeat counter must hold the larger of the two intervals without wrapping.
  function automatic int unsigned repeat_cnt_w(input int unsigned hold_cyc,
                                               input int unsigned repeat_cyc);
    int unsigned mx;
    mx = (hold_cyc > repeat_cyc) ? hold_cyc : repeat_cyc;
    return (mx < 1) ? 1 : $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/cursor_select_ctrl_btn_edge_repeat.sv
// One button: 2-flop synchronizer, rising-edge pulse and an optional
// hold-to-repeat generator that adds extra pulses while the level stays high.
module btn_edge_repeat
  import lianliankan_pkg::*;
#(
  parameter bit          REPEAT_EN  = 1'b1,
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic ev_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int unsigned CW = repeat_cnt_w(HOLD_CYC, REPEAT_CYC);
      localparam logic [CW-1:0] HOLD_V = CW'(HOLD_CYC);
      localparam logic [CW-1:0] REP_V  = CW'(REPEAT_CYC);
      localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          phase_q;
      logic          phase_d;
      logic          rep;

      // cnt_q equals the number of cycles since the last emitted event while
      // held; phase_q selects the initial hold vs. the steady repeat interval.
      always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        rep     = 1'b0;
        if (!sync2_q) begin
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (cnt_q == (phase_q ? REP_V : HOLD_V)) begin
          rep     = 1'b1;
          cnt_d   = CW'(1);
          phase_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q   <= '0;
          phase_q <= 1'b0;
        end else begin
          cnt_q   <= cnt_d;
          phase_q <= phase_d;
        end
      end

      assign ev_o = rise | rep;
    end else begin : g_norep
      assign ev_o = rise;
    end
  endgenerate

endmodule

// File: rtl/cursor_select_ctrl.sv
// Board cursor with wrap-around moves and auto-repeat, plus a two-cell
// selection FSM that offers completed pairs over a valid/ack handshake.
module cursor_select_ctrl
  import lianliankan_pkg::*;
#(
  parameter int unsigned COLS       = BOARD_COLS,
  parameter int unsigned ROWS       = BOARD_ROWS,
  parameter int unsigned XW         = BOARD_XW,
  parameter int unsigned YW         = BOARD_YW,
  parameter int unsigned HOLD_CYC   = 50_000_000,
  parameter int unsigned REPEAT_CYC = 10_000_000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_in,
  input  logic          right_in,
  input  logic          down_in,
  input  logic          left_in,
  input  logic          s_in,
  output logic [XW-1:0] cur_x,
  output logic [YW-1:0] cur_y,
  output logic          sel_valid,
  output logic [XW-1:0] sel_x,
  output logic [YW-1:0] sel_y,
  output logic          pair_valid,
  output logic [XW-1:0] pair_x0,
  output logic [YW-1:0] pair_y0,
  output logic [XW-1:0] pair_x1,
  output logic [YW-1:0] pair_y1,
  input  logic          pair_ack
);

  localparam logic [XW-1:0] X_MAX = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(ROWS - 1);

  logic up_ev, right_ev, down_ev, left_ev, s_ev;

  btn_edge_repeat #(.REPEAT_EN(1'b1), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC))
    u_up    (.clk(clk), .rst(rst), .btn_in(up_in),    .ev_o(up_ev));
  btn_edge_repeat #(.REPEAT_EN(1'b1), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC))
    u_right (.clk(clk), .rst(rst), .btn_in(right_in), .ev_o(right_ev));
  btn_edge_repeat #(.REPEAT_EN(1'b1), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC))
    u_down  (.clk(clk), .rst(rst), .btn_in(down_in),  .ev_o(down_ev));
  btn_edge_repeat #(.REPEAT_EN(1'b1), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC))
    u_left  (.clk(clk), .rst(rst), .btn_in(left_in),  .ev_o(left_ev));
  btn_edge_repeat #(.REPEAT_EN(1'b0), .HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC))
    u_sel   (.clk(clk), .rst(rst), .btn_in(s_in),     .ev_o(s_ev));

  logic [XW-1:0] cur_x_q, cur_x_d;
  logic [YW-1:0] cur_y_q, cur_y_d;
  sel_state_e    state_q, state_d;
  logic          sel_valid_q, sel_valid_d;
  logic [XW-1:0] sel_x_q, sel_x_d;
  logic [YW-1:0] sel_y_q, sel_y_d;
  logic          pair_valid_q, pair_valid_d;
  logic [XW-1:0] pair_x0_q, pair_x0_d, pair_x1_q, pair_x1_d;
  logic [YW-1:0] pair_y0_q, pair_y0_d, pair_y1_q, pair_y1_d;

  // One move per cycle; coincident lower-priority events are dropped.
  always_comb begin
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    if (up_ev) begin
      cur_y_d = (cur_y_q == '0) ? Y_MAX : cur_y_q - 1'b1;
    end else if (right_ev) begin
      cur_x_d = (cur_x_q == X_MAX) ? '0 : cur_x_q + 1'b1;
    end else if (down_ev) begin
      cur_y_d = (cur_y_q == Y_MAX) ? '0 : cur_y_q + 1'b1;
    end else if (left_ev) begin
      cur_x_d = (cur_x_q == '0) ? X_MAX : cur_x_q - 1'b1;
    end
  end

  // Selection reads the registered (pre-move) cursor.
  always_comb begin
    state_d      = state_q;
    sel_valid_d  = sel_valid_q;
    sel_x_d      = sel_x_q;
    sel_y_d      = sel_y_q;
    pair_valid_d = pair_valid_q;
    pair_x0_d    = pair_x0_q;
    pair_y0_d    = pair_y0_q;
    pair_x1_d    = pair_x1_q;
    pair_y1_d    = pair_y1_q;
    case (state_q)
      SEL_IDLE: begin
        if (s_ev) begin
          sel_x_d     = cur_x_q;
          sel_y_d     = cur_y_q;
          sel_valid_d = 1'b1;
          state_d     = SEL_ONE;
        end
      end
      SEL_ONE: begin
        if (s_ev) begin
          sel_valid_d = 1'b0;
          if (cur_x_q == sel_x_q && cur_y_q == sel_y_q) begin
            state_d = SEL_IDLE;
          end else begin
            pair_x0_d    = sel_x_q;
            pair_y0_d    = sel_y_q;
            pair_x1_d    = cur_x_q;
            pair_y1_d    = cur_y_q;
            pair_valid_d = 1'b1;
            state_d      = SEL_PEND;
          end
        end
      end
      SEL_PEND: begin
        if (pair_ack) begin
          pair_valid_d = 1'b0;
          state_d      = SEL_IDLE;
        end
      end
      default: begin
        state_d      = SEL_IDLE;
        sel_valid_d  = 1'b0;
        pair_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      state_q      <= SEL_IDLE;
      sel_valid_q  <= 1'b0;
      sel_x_q      <= '0;
      sel_y_q      <= '0;
      pair_valid_q <= 1'b0;
      pair_x0_q    <= '0;
      pair_y0_q    <= '0;
      pair_x1_q    <= '0;
      pair_y1_q    <= '0;
    end else begin
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      state_q      <= state_d;
      sel_valid_q  <= sel_valid_d;
      sel_x_q      <= sel_x_d;
      sel_y_q      <= sel_y_d;
      pair_valid_q <= pair_valid_d;
      pair_x0_q    <= pair_x0_d;
      pair_y0_q    <= pair_y0_d;
      pair_x1_q    <= pair_x1_d;
      pair_y1_q    <= pair_y1_d;
    end
  end

  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;
  assign sel_valid  = sel_valid_q;
  assign sel_x      = sel_x_q;
  assign sel_y      = sel_y_q;
  assign pair_valid = pair_valid_q;
  assign pair_x0    = pair_x0_q;
  assign pair_y0    = pair_y0_q;
  assign pair_x1    = pair_x1_q;
  assign pair_y1    = pair_y1_q;

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// Bench for cursor_select_ctrl: directed scenarios with literal expectations
// followed by randomized button/ack/reset traffic checked against a model.
module tb_cursor_select_ctrl;

  localparam int COLS = 8;
  localparam int ROWS = 8;
  localparam int XW   = 3;
  localparam int YW   = 3;
  localparam int HOLD = 20;
  localparam int REP  = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic up_in = 1'b0, right_in = 1'b0, down_in = 1'b0, left_in = 1'b0, s_in = 1'b0;
  logic pair_ack = 1'b0;
  logic [XW-1:0] cur_x, sel_x, pair_x0, pair_x1;
  logic [YW-1:0] cur_y, sel_y, pair_y0, pair_y1;
  logic sel_valid, pair_valid;

  always #5 clk = ~clk;

  cursor_select_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .XW(XW), .YW(YW), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
  ) dut (
    .clk(clk), .rst(rst),
    .up_in(up_in), .right_in(right_in), .down_in(down_in), .left_in(left_in), .s_in(s_in),
    .cur_x(cur_x), .cur_y(cur_y),
    .sel_valid(sel_valid), .sel_x(sel_x), .sel_y(sel_y),
    .pair_valid(pair_valid),
    .pair_x0(pair_x0), .pair_y0(pair_y0), .pair_x1(pair_x1), .pair_y1(pair_y1),
    .pair_ack(pair_ack)
  );

  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;

  // Model: each button's level is seen two edges late; an event fires on the
  // first cycle of a high run and at HOLD, HOLD+REP, ... cycles into it.
  int m_x = 0, m_y = 0;
  bit m_sel = 1'b0, m_pair = 1'b0;
  int m_sx = 0, m_sy = 0, m_px0 = 0, m_py0 = 0, m_px1 = 0, m_py1 = 0;
  bit d1 [5];
  bit d2 [5];
  int run [5];
  bit xin [5];
  bit ev [5];

  always @(posedge clk) begin
    xin = '{up_in, right_in, down_in, left_in, s_in};
    if (rst) begin
      m_x = 0; m_y = 0; m_sel = 1'b0; m_pair = 1'b0;
      for (int b = 0; b < 5; b++) begin
        d1[b] = 1'b0; d2[b] = 1'b0; run[b] = 0;
      end
    end else begin
      for (int b = 0; b < 5; b++) begin
        int k;
        run[b] = d2[b] ? run[b] + 1 : 0;
        k = run[b] - 1;
        ev[b] = (run[b] > 0) &&
                (k == 0 || (b != 4 && k >= HOLD && ((k - HOLD) % REP) == 0));
      end
      if (m_pair) begin
        if (pair_ack) m_pair = 1'b0;
      end else if (ev[4]) begin
        if (!m_sel) begin
          m_sel = 1'b1; m_sx = m_x; m_sy = m_y;
        end else if (m_sx == m_x && m_sy == m_y) begin
          m_sel = 1'b0;
        end else begin
          m_sel = 1'b0; m_pair = 1'b1;
          m_px0 = m_sx; m_py0 = m_sy; m_px1 = m_x; m_py1 = m_y;
        end
      end
      if (ev[0])      m_y = (m_y + ROWS - 1) % ROWS;
      else if (ev[1]) m_x = (m_x + 1) % COLS;
      else if (ev[2]) m_y = (m_y + 1) % ROWS;
      else if (ev[3]) m_x = (m_x + COLS - 1) % COLS;
      for (int b = 0; b < 5; b++) begin
        d2[b] = d1[b]; d1[b] = xin[b];
      end
    end
  end

  // Every-cycle comparison of registered outputs against the model.
  always @(negedge clk) begin
    if (!done) begin
      bit bad;
      bad = 1'b0;
      if (cur_x !== XW'(m_x) || cur_y !== YW'(m_y)) bad = 1'b1;
      if (sel_valid !== m_sel || pair_valid !== m_pair) bad = 1'b1;
      if (m_sel && (sel_x !== XW'(m_sx) || sel_y !== YW'(m_sy))) bad = 1'b1;
      if (m_pair && (pair_x0 !== XW'(m_px0) || pair_y0 !== YW'(m_py0) ||
                     pair_x1 !== XW'(m_px1) || pair_y1 !== YW'(m_py1))) bad = 1'b1;
      vectors++;
      if (bad) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t got cur=(%0d,%0d) sel=%0b(%0d,%0d) pair=%0b(%0d,%0d,%0d,%0d) want cur=(%0d,%0d) sel=%0b(%0d,%0d) pair=%0b(%0d,%0d,%0d,%0d)",
                 $time, cur_x, cur_y, sel_valid, sel_x, sel_y, pair_valid,
                 pair_x0, pair_y0, pair_x1, pair_y1, m_x, m_y, m_sel, m_sx, m_sy,
                 m_pair, m_px0, m_py0, m_px1, m_py1);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: up_in = v;
      1: right_in = v;
      2: down_in = v;
      3: left_in = v;
      default: s_in = v;
    endcase
  endtask

  task automatic press(input int b);
    @(negedge clk); set_btn(b, 1'b1);
    @(negedge clk); set_btn(b, 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  int exp_mv [5] = '{3, 23, 28, 33, 38};

  initial begin
    int moves;
    int prevx;
    int slow;
    int tp;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_cur_x", cur_x, 0);
    chk("rst_cur_y", cur_y, 0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_pair_valid", pair_valid, 0);
    chk("rst_sel_x", sel_x, 0);
    chk("rst_pair_x1", pair_x1, 0);

    // Single pulses: left wraps x, then up wraps y; change lands on edge 3.
    @(negedge clk); left_in = 1'b1;
    @(negedge clk); left_in = 1'b0;
    @(negedge clk); chk("left_edge2_x", cur_x, 0);
    @(negedge clk); chk("left_edge3_x", cur_x, 7); chk("left_edge3_y", cur_y, 0);
    repeat (3) @(negedge clk);
    @(negedge clk); up_in = 1'b1;
    @(negedge clk); up_in = 1'b0;
    @(negedge clk); chk("up_edge2_y", cur_y, 0);
    @(negedge clk); chk("up_edge3_y", cur_y, 7); chk("up_edge3_x", cur_x, 7);
    repeat (3) @(negedge clk);

    // Held right: initial move then auto-repeats.
    do_reset();
    repeat (2) @(negedge clk);
    prevx = cur_x;
    moves = 0;
    @(negedge clk); right_in = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 40) right_in = 1'b0;
      if (int'(cur_x) != prevx) begin
        if (moves < 5) chk("repeat_move_cycle", i, exp_mv[moves]);
        else chk("repeat_extra_move", i, -1);
        moves++;
        prevx = cur_x;
      end
    end
    chk("repeat_move_count", moves, 5);
    chk("repeat_final_x", cur_x, 5);

    // Coincident up+left at (3,3): only up applies.
    do_reset();
    repeat (3) press(1);
    repeat (3) press(2);
    chk("pos33_x", cur_x, 3); chk("pos33_y", cur_y, 3);
    @(negedge clk); up_in = 1'b1; left_in = 1'b1;
    @(negedge clk); up_in = 1'b0; left_in = 1'b0;
    repeat (4) @(negedge clk);
    chk("prio_x", cur_x, 3); chk("prio_y", cur_y, 2);

    // Select then cancel at (2,2).
    press(3);
    press(4);
    chk("sel_valid_set", sel_valid, 1);
    chk("sel_x", sel_x, 2); chk("sel_y", sel_y, 2);
    press(4);
    chk("sel_cancel", sel_valid, 0);
    chk("cancel_no_pair", pair_valid, 0);

    // Pair (1,1)->(4,6) with handshake.
    press(3); press(0);
    press(4);
    chk("pair_first_sel", sel_valid, 1);
    repeat (3) press(1);
    repeat (5) press(2);
    press(4);
    chk("pair_valid_set", pair_valid, 1);
    chk("pair_sel_cleared", sel_valid, 0);
    chk("pair_x0", pair_x0, 1); chk("pair_y0", pair_y0, 1);
    chk("pair_x1", pair_x1, 4); chk("pair_y1", pair_y1, 6);
    repeat (10) @(negedge clk);
    chk("pair_hold_noack", pair_valid, 1);
    press(4); press(4);
    chk("pair_hold_s", pair_valid, 1);
    chk("pair_hold_x1", pair_x1, 4);
    chk("pair_hold_sel", sel_valid, 0);
    @(negedge clk); pair_ack = 1'b1;
    @(negedge clk); pair_ack = 1'b0;
    chk("pair_ack_drop", pair_valid, 0);

    // Reset while a pair is pending.
    repeat (3) @(negedge clk);
    press(4); press(1); press(4);
    chk("pend2_valid", pair_valid, 1);
    do_reset();
    chk("rst_pend_pair", pair_valid, 0);
    chk("rst_pend_sel", sel_valid, 0);
    chk("rst_pend_x", cur_x, 0); chk("rst_pend_y", cur_y, 0);
    press(4);
    chk("fresh_sel_valid", sel_valid, 1);
    chk("fresh_sel_x", sel_x, 0); chk("fresh_sel_y", sel_y, 0);

    // Randomized traffic, alternating busy and long-hold phases.
    slow = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (i % 200 == 0) slow = $urandom_range(0, 1);
      tp = slow ? 40 : 6;
      if ($urandom_range(0, tp - 1) == 0) up_in    = ~up_in;
      if ($urandom_range(0, tp - 1) == 0) right_in = ~right_in;
      if ($urandom_range(0, tp - 1) == 0) down_in  = ~down_in;
      if ($urandom_range(0, tp - 1) == 0) left_in  = ~left_in;
      if ($urandom_range(0, 4) == 0)      s_in     = ~s_in;
      pair_ack = ($urandom_range(0, 5) == 0);
      rst = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    up_in = 1'b0; right_in = 1'b0; down_in = 1'b0; left_in = 1'b0; s_in = 1'b0;
    pair_ack = 1'b0; rst = 1'b0;
    repeat (6) @(negedge clk);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
